// File: rtl/seg_scan_decoder_pkg.sv
// rtl/seg_scan_decoder_pkg.sv - shared seven-segment pattern constants and digit-kind encoding
//
// Patterns are active-low (0 = lit). Bit 6 is segment A and bit 0 is segment G.
// Index i of seg_hex holds the pattern for hex value i.
package seg_scan_decoder_pkg;

    typedef enum logic [1:0] {
        KIND_HEX     = 2'b00,
        KIND_DASH    = 2'b01,
        KIND_BLANK   = 2'b10,
        KIND_INVALID = 2'b11
    } seg_kind_e;

    localparam logic [6:0] SEG_HEX [16] = '{
        7'b0000001,  // 0
        7'b1001111,  // 1
        7'b0010010,  // 2
        7'b0000110,  // 3
        7'b1001100,  // 4
        7'b0100100,  // 5
        7'b0100000,  // 6
        7'b0001111,  // 7
        7'b0000000,  // 8
        7'b0000100,  // 9
        7'b0001000,  // A
        7'b1100000,  // b
        7'b0110001,  // C
        7'b1000010,  // d
        7'b0110000,  // E
        7'b0111000   // F
    };

    localparam logic [6:0] SEG_DASH  = 7'b1111110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

// File: rtl/seg_pattern_decode.sv
// rtl/seg_pattern_decode.sv - combinational seven-segment pattern to nibble/kind decoder
//
// Ports:
//   pattern  in   7  active-low segment pattern (bit 6 = A .. bit 0 = G)
//   nibble   out  4  hex value for hex patterns, 0 otherwise
//   kind     out  2  hex / dash / blank / invalid class
module seg_pattern_decode
    import seg_scan_decoder_pkg::*;
(
    input  logic [6:0] pattern,
    output logic [3:0] nibble,
    output seg_kind_e  kind
);

    always_comb begin
        nibble = 4'h0;
        if (pattern == SEG_DASH) begin
            kind = KIND_DASH;
        end else if (pattern == SEG_BLANK) begin
            kind = KIND_BLANK;
        end else begin
            kind = KIND_INVALID;
        end
        // Hex patterns are all distinct from dash and blank, so the search
        // simply overrides the default class when a match is found.
        for (int i = 0; i < 16; i++) begin
            if (pattern == SEG_HEX[i]) begin
                nibble = 4'(i);
                kind   = KIND_HEX;
            end
        end
    end

endmodule

// File: rtl/seg_scan_decoder.sv
// rtl/seg_scan_decoder.sv - recovers four digits from a scanned seven-segment display drive
//
// Ports:
//   clk         in   1   clock, rising edge
//   rst         in   1   synchronous active-high reset
//   an          in   4   anode enables, active-low, an[i] selects digit i
//   seven       in   7   segment pattern, active-low
//   digits      out  16  decoded nibble for digit i at [4i+3:4i]
//   kind        out  8   class for digit i at [2i+1:2i]
//   captured    out  4   digits accepted in the current frame
//   frame_done  out  1   one-cycle pulse after all four digits are accepted
//   stale       out  1   no acceptance for STALE_CYCLES cycles
module seg_scan_decoder
    import seg_scan_decoder_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int STALE_CYCLES  = 1048576
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  an,
    input  logic [6:0]  seven,
    output logic [15:0] digits,
    output logic [7:0]  kind,
    output logic [3:0]  captured,
    output logic        frame_done,
    output logic        stale
);

    localparam int          SW         = $clog2(STALE_CYCLES + 1);
    localparam logic [3:0]  STABLE_MAX = 4'(STABLE_CYCLES);
    localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);

    // Sampled input pair and the pair seen one edge earlier
    logic [3:0]    an_r;
    logic [6:0]    seven_r;
    logic [3:0]    an_p;
    logic [6:0]    seven_p;
    logic [3:0]    stab_cnt;
    logic [SW-1:0] stale_cnt;

    logic          pair_valid;
    logic [1:0]    idx;
    logic          same_pair;
    logic [3:0]    stab_next;
    logic          accept;
    logic [3:0]    cap_next;
    logic [3:0]    dec_nibble;
    seg_kind_e     dec_kind;

    seg_pattern_decode u_dec (
        .pattern (seven_r),
        .nibble  (dec_nibble),
        .kind    (dec_kind)
    );

    always_comb begin
        pair_valid = 1'b0;
        idx        = 2'd0;
        case (an_r)
            4'b1110: begin pair_valid = 1'b1; idx = 2'd0; end
            4'b1101: begin pair_valid = 1'b1; idx = 2'd1; end
            4'b1011: begin pair_valid = 1'b1; idx = 2'd2; end
            4'b0111: begin pair_valid = 1'b1; idx = 2'd3; end
            default: begin pair_valid = 1'b0; idx = 2'd0; end
        endcase
    end

    assign same_pair = (an_r == an_p) && (seven_r == seven_p);

    always_comb begin
        if (!pair_valid) begin
            stab_next = 4'd0;
        end else if (same_pair) begin
            stab_next = (stab_cnt == STABLE_MAX) ? STABLE_MAX : stab_cnt + 4'd1;
        end else begin
            stab_next = 4'd1;
        end
    end

    // Fires only on the edge the counter arrives at the threshold, so a long
    // stable run is accepted once rather than every cycle.
    assign accept   = pair_valid && (stab_next == STABLE_MAX) && (stab_cnt != STABLE_MAX);
    assign cap_next = captured | (4'b0001 << idx);
    assign stale    = (stale_cnt == STALE_MAX);

    always_ff @(posedge clk) begin
        if (rst) begin
            an_r       <= 4'b1111;
            seven_r    <= 7'b1111111;
            an_p       <= 4'b1111;
            seven_p    <= 7'b1111111;
            stab_cnt   <= 4'd0;
            stale_cnt  <= '0;
            digits     <= 16'h0000;
            kind       <= 8'b10101010;
            captured   <= 4'b0000;
            frame_done <= 1'b0;
        end else begin
            an_r       <= an;
            seven_r    <= seven;
            an_p       <= an_r;
            seven_p    <= seven_r;
            stab_cnt   <= stab_next;
            frame_done <= 1'b0;

            if (accept) begin
                stale_cnt               <= '0;
                digits[4*idx +: 4]      <= dec_nibble;
                kind[2*idx +: 2]        <= dec_kind;
                // A completed frame restarts collection on the same edge.
                if (cap_next == 4'b1111) begin
                    captured   <= 4'b0000;
                    frame_done <= 1'b1;
                end else begin
                    captured   <= cap_next;
                end
            end else if (stale_cnt != STALE_MAX) begin
                stale_cnt <= stale_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_seg_scan_decoder.sv
// tb/tb_seg_scan_decoder.sv - self-checking bench for seg_scan_decoder
module tb_seg_scan_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  an = 4'b1111;
    logic [6:0]  seven = 7'b1111111;
    logic [15:0] digits;
    logic [7:0]  kind;
    logic [3:0]  captured;
    logic        frame_done;
    logic        stale;

    int checks = 0;
    int errors = 0;

    seg_scan_decoder #(
        .STABLE_CYCLES (4),
        .STALE_CYCLES  (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .an         (an),
        .seven      (seven),
        .digits     (digits),
        .kind       (kind),
        .captured   (captured),
        .frame_done (frame_done),
        .stale      (stale)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0] pat;
        logic [3:0] nib;
        logic [1:0] knd;
    } vec_t;

    typedef struct {
        int         idx;
        logic [3:0] nib;
        logic [1:0] knd;
    } exp_t;

    vec_t vec [20];
    exp_t sb [$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic reset_dut();
        rst   = 1'b1;
        an    = 4'b1111;
        seven = 7'b1111111;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_digits"},   32'(digits),     32'h0);
        chk({tag, "_kind"},     32'(kind),       32'hAA);
        chk({tag, "_captured"}, 32'(captured),   32'h0);
        chk({tag, "_frame"},    32'(frame_done), 32'h0);
        chk({tag, "_stale"},    32'(stale),      32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int   pulses;
        int   edges;
        exp_t e;
        logic [6:0] scan_pat [4];

        vec[0]  = '{7'b0000001, 4'h0, 2'b00};
        vec[1]  = '{7'b1001111, 4'h1, 2'b00};
        vec[2]  = '{7'b0010010, 4'h2, 2'b00};
        vec[3]  = '{7'b0000110, 4'h3, 2'b00};
        vec[4]  = '{7'b1001100, 4'h4, 2'b00};
        vec[5]  = '{7'b0100100, 4'h5, 2'b00};
        vec[6]  = '{7'b0100000, 4'h6, 2'b00};
        vec[7]  = '{7'b0001111, 4'h7, 2'b00};
        vec[8]  = '{7'b0000000, 4'h8, 2'b00};
        vec[9]  = '{7'b0000100, 4'h9, 2'b00};
        vec[10] = '{7'b0001000, 4'hA, 2'b00};
        vec[11] = '{7'b1100000, 4'hB, 2'b00};
        vec[12] = '{7'b0110001, 4'hC, 2'b00};
        vec[13] = '{7'b1000010, 4'hD, 2'b00};
        vec[14] = '{7'b0110000, 4'hE, 2'b00};
        vec[15] = '{7'b0111000, 4'hF, 2'b00};
        vec[16] = '{7'b1111110, 4'h0, 2'b01};
        vec[17] = '{7'b1111111, 4'h0, 2'b10};
        vec[18] = '{7'b1010101, 4'h0, 2'b11};
        vec[19] = '{7'b0111111, 4'h0, 2'b11};

        reset_dut();
        chk_reset_state("reset");

        // Table: each pattern on one digit, accepted on the fifth edge after it is applied
        for (int k = 0; k < 20; k++) begin
            reset_dut();
            an    = ~(4'b0001 << (k % 4));
            seven = vec[k].pat;
            sb.push_back('{k % 4, vec[k].nib, vec[k].knd});
            edges = 0;
            while (captured[k % 4] !== 1'b1 && edges < 12) begin
                tick();
                edges++;
            end
            e = sb.pop_front();
            chk($sformatf("vec%0d_latency", k), 32'(edges), 32'd5);
            chk($sformatf("vec%0d_nibble", k), 32'(digits[4*e.idx +: 4]), 32'(e.nib));
            chk($sformatf("vec%0d_kind", k), 32'(kind[2*e.idx +: 2]), 32'(e.knd));
        end

        // Run broken after three cycles is never accepted
        reset_dut();
        an    = 4'b1101;
        seven = 7'b0010010;
        repeat (3) tick();
        seven = 7'b0000110;
        repeat (3) tick();
        chk("short_run_captured", 32'(captured), 32'h0);
        chk("short_run_digits", 32'(digits), 32'h0);

        // Full frame scan: 1, 2, F, dash
        reset_dut();
        scan_pat[0] = 7'b1001111;
        scan_pat[1] = 7'b0010010;
        scan_pat[2] = 7'b0111000;
        scan_pat[3] = 7'b1111110;
        pulses = 0;
        for (int d = 0; d < 4; d++) begin
            an    = ~(4'b0001 << d);
            seven = scan_pat[d];
            for (int c = 0; c < 8; c++) begin
                tick();
                if (frame_done === 1'b1) pulses++;
            end
        end
        an = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            if (frame_done === 1'b1) pulses++;
        end
        chk("frame_digits", 32'(digits), 32'h0F21);
        chk("frame_kind", 32'(kind), 32'b01000000);
        chk("frame_pulses", 32'(pulses), 32'd1);
        chk("frame_captured", 32'(captured), 32'h0);

        // Re-acceptance of digit 0 overwrites without completing a frame
        pulses = 0;
        an     = 4'b1110;
        seven  = 7'b0000000;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (frame_done === 1'b1) pulses++;
        end
        seven = 7'b0000100;
        for (int c = 0; c < 8; c++) begin
            tick();
            if (frame_done === 1'b1) pulses++;
        end
        chk("reaccept_digit", 32'(digits[3:0]), 32'h9);
        chk("reaccept_captured", 32'(captured), 32'b0001);
        chk("reaccept_pulses", 32'(pulses), 32'd0);

        // Invalid anode patterns, then an invalid segment pattern on digit 3
        reset_dut();
        an    = 4'b1100;
        seven = 7'b0000000;
        repeat (10) tick();
        an = 4'b1111;
        repeat (10) tick();
        chk("bad_an_captured", 32'(captured), 32'h0);
        chk("bad_an_digits", 32'(digits), 32'h0);
        chk("bad_an_kind", 32'(kind), 32'hAA);
        an    = 4'b0111;
        seven = 7'b1010101;
        repeat (6) tick();
        chk("inv_pat_kind", 32'(kind[7:6]), 32'h3);
        chk("inv_pat_digit", 32'(digits[15:12]), 32'h0);
        chk("inv_pat_captured", 32'(captured), 32'b1000);

        // Stale after 16 idle cycles, cleared by the next acceptance
        reset_dut();
        repeat (15) tick();
        chk("stale_before", 32'(stale), 32'h0);
        tick();
        chk("stale_set", 32'(stale), 32'h1);
        an    = 4'b1110;
        seven = 7'b1001111;
        repeat (4) tick();
        chk("stale_held", 32'(stale), 32'h1);
        tick();
        chk("stale_cleared", 32'(stale), 32'h0);
        chk("stale_capture", 32'(captured), 32'b0001);

        // Reset in the middle of a scan discards partial state
        an    = 4'b1101;
        seven = 7'b0010010;
        repeat (3) tick();
        rst = 1'b1;
        tick();
        chk_reset_state("midrst");
        rst   = 1'b0;
        an    = 4'b1011;
        seven = 7'b0000001;
        edges = 0;
        while (captured[2] !== 1'b1 && edges < 12) begin
            tick();
            edges++;
        end
        chk("midrst_latency", 32'(edges), 32'd5);
        chk("midrst_captured", 32'(captured), 32'b0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
